picorv_hpdc_seq: RTL and testbench
==================================

Name: picorv_hpdc_seq

Overview:
- Request sequencer between the picorv32 native memory port and requester port 0 of hpdcache_wrapper.
- Converts the picorv32 valid/ready handshake into an hpdcache request/response transaction, with at most one access outstanding.
- Classifies each address as cacheable or MMIO. Before any MMIO access, drains the hpdcache write buffer so stores reach memory in program order.
- Bounds every access with a timeout so a lost response cannot hang the core.

Parameters:
- PhysMemLimit, 32'h20000: addresses >= this are uncacheable/io.
- TimeoutCycles, 1024: cycles allowed in FLUSH plus WAIT_RSP before the access is aborted.
- ReqSid, 0: source ID driven on every request.
- ErrRdata, 32'hDEADBEEF: read data returned on timeout or error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- mem_valid_i  in  1  picorv32 mem_valid.
- mem_addr_i  in  32  picorv32 mem_addr.
- mem_wdata_i  in  32  picorv32 mem_wdata.
- mem_wstrb_i  in  4  picorv32 mem_wstrb; nonzero means store.
- mem_ready_o  out  1  picorv32 mem_ready; single-cycle pulse.
- mem_rdata_o  out  32  picorv32 mem_rdata; valid while mem_ready_o is high.
- core_req_valid_o  out  1  hpdcache request valid.
- core_req_ready_i  in  1  hpdcache request ready.
- core_req_o  out  hpdcache_req_t  hpdcache request payload.
- core_req_abort_o  out  1  tied 0.
- core_req_tag_o  out  hpdcache_tag_t  physical tag.
- core_rsp_valid_i  in  1  hpdcache response valid.
- core_rsp_i  in  hpdcache_rsp_t  hpdcache response payload.
- wbuf_flush_o  out  1  write-buffer flush request.
- wbuf_empty_i  in  1  write buffer is empty.
- err_o  out  1  one-cycle pulse on timeout or rsp.error.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- FSM states: IDLE, FLUSH, REQ, WAIT_RSP, DONE.
- IDLE:
  - On mem_valid_i, latch addr, wdata and wstrb.
  - Compute io = (addr >= PhysMemLimit).
  - If io, go to FLUSH; otherwise go to REQ.
  - Inputs are sampled only in IDLE; later changes to picorv32 inputs are ignored.
- FLUSH:
  - wbuf_flush_o = 1.
  - When wbuf_empty_i = 1, go to REQ. If wbuf_empty_i is already 1 on entry, FLUSH lasts exactly 1 cycle.
- REQ:
  - core_req_valid_o = 1, payload held stable until core_req_ready_i.
  - Transfer happens on the cycle where valid && ready; then go to WAIT_RSP.
  - Payload fields:
    - addr_offset = addr[reqOffsetWidth-1:0]; addr_tag = core_req_tag_o = addr[31 -: tagWidth].
    - op = STORE if |wstrb, else LOAD; be = wstrb (all-ones for loads); size = 2; wdata = latched wdata.
    - sid = ReqSid; tid = 0; need_rsp = 1; phys_indexed = 1.
    - pma.uncacheable = pma.io = io; pma.wr_policy_hint = WB.
- WAIT_RSP:
  - Accept core_rsp_valid_i only when rsp.sid == ReqSid and rsp.tid == 0. Responses that do not match are ignored.
  - On an accepted response, register rdata (ErrRdata if rsp.error); if rsp.error, pulse err_o. Go to DONE.
- DONE:
  - mem_ready_o = 1 for exactly one cycle, with mem_rdata_o valid in that cycle; then go to IDLE.
  - Stores also complete through DONE; their rdata is don't-care.
- Latency: cacheable access with ready and response both combinationally available is 4 cycles from mem_valid_i to mem_ready_o. Each FLUSH cycle adds 1.
- Back-to-back accesses: picorv32 may re-raise mem_valid_i the cycle after mem_ready_o; IDLE accepts it immediately.
- Timeout:
  - Counter is cleared on leaving IDLE and increments in FLUSH and WAIT_RSP. It does not run in REQ, because backpressure from the cache is legal.
  - When the counter reaches TimeoutCycles-1, go to DONE with rdata = ErrRdata and pulse err_o.
  - Because a request is already in flight on timeout, a late matching response arriving after DONE must be dropped. Implement with a 1-bit stale flag: set on timeout-from-WAIT_RSP, cleared by the next matching response. While stale is set, IDLE does not leave for REQ.
- Simultaneous events: a timeout and an accepted response in the same cycle resolve as the response (no error).
- Reset asserted mid-access: the FSM returns to IDLE asynchronously and any outstanding hpdcache response is discarded. This is acceptable because the whole SoC resets together.

Decomposition:
- Shared package picorv_hpdc_pkg holds:
  - state enum seq_state_e;
  - PHYS_MEM_LIMIT and ERR_RDATA constants;
  - function is_io(addr);
  - function build_req(addr, wdata, wstrb, io) returning hpdcache_req_t.
- One sub-module: seq_timeout_ctr, a parameterised counter with clear, enable and expire outputs.
- FSM, latches and stale flag stay in the top module.

Test Plan:
- Cacheable load: addr 0x100, ready=1, response rdata 0x12345678 one cycle after transfer -> one request with op LOAD, uncacheable=0; mem_ready_o pulses once with mem_rdata_o = 0x12345678, 4 cycles after mem_valid_i.
- Store with backpressure: addr 0x200, wstrb 4'b0011, wdata 0xAABBCCDD, core_req_ready_i low for 5 cycles -> payload stable across all 5 cycles; be = 0011; exactly one transfer; mem_ready_o after the response.
- MMIO store: addr 0x30000, wbuf_empty_i low for 3 cycles -> wbuf_flush_o high 3 cycles, no request until wbuf_empty_i rises; pma.io = pma.uncacheable = 1.
- Boundary: addr 0x1FFFC -> cacheable; addr 0x20000 -> io.
- Timeout: TimeoutCycles = 16, no response -> mem_ready_o with rdata 0xDEADBEEF and err_o pulse; a late response is dropped; the next access completes normally.
- Error response and async reset: rsp.error=1 -> rdata 0xDEADBEEF and err_o pulse; rst_ni low while in WAIT_RSP -> all outputs 0 immediately, FSM back in IDLE.

Source files
------------

// File: rtl/picorv_hpdc_pkg.sv
// rtl/picorv_hpdc_pkg.sv - shared types, constants and helpers for the picorv32 to hpdcache sequencer
package picorv_hpdc_pkg;

  localparam int unsigned REQ_OFFSET_WIDTH = 12;
  localparam int unsigned TAG_WIDTH        = 32 - REQ_OFFSET_WIDTH;
  localparam int unsigned SID_WIDTH        = 3;
  localparam int unsigned TID_WIDTH        = 6;

  localparam logic [31:0] PHYS_MEM_LIMIT = 32'h0002_0000;
  localparam logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    REQ      = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    HPDCACHE_REQ_LOAD  = 2'd0,
    HPDCACHE_REQ_STORE = 2'd1
  } hpdcache_req_op_e;

  typedef enum logic {
    HPDCACHE_WR_POLICY_WB = 1'b0,
    HPDCACHE_WR_POLICY_WT = 1'b1
  } hpdcache_wr_policy_e;

  typedef logic [TAG_WIDTH-1:0] hpdcache_tag_t;

  typedef struct packed {
    logic                uncacheable;
    logic                io;
    hpdcache_wr_policy_e wr_policy_hint;
  } hpdcache_pma_t;

  typedef struct packed {
    logic [REQ_OFFSET_WIDTH-1:0] addr_offset;
    logic [31:0]                 wdata;
    hpdcache_req_op_e            op;
    logic [3:0]                  be;
    logic [2:0]                  size;
    logic [SID_WIDTH-1:0]        sid;
    logic [TID_WIDTH-1:0]        tid;
    logic                        need_rsp;
    logic                        phys_indexed;
    hpdcache_tag_t               addr_tag;
    hpdcache_pma_t               pma;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0]          rdata;
    logic [SID_WIDTH-1:0] sid;
    logic [TID_WIDTH-1:0] tid;
    logic                 error;
  } hpdcache_rsp_t;

  function automatic logic is_io(input logic [31:0] addr,
                                 input logic [31:0] limit = PHYS_MEM_LIMIT);
    return addr >= limit;
  endfunction

  function automatic hpdcache_req_t build_req(input logic [31:0]          addr,
                                              input logic [31:0]          wdata,
                                              input logic [3:0]           wstrb,
                                              input logic                 io,
                                              input logic [SID_WIDTH-1:0] sid = '0);
    hpdcache_req_t r;
    r                    = '0;
    r.addr_offset        = addr[REQ_OFFSET_WIDTH-1:0];
    r.addr_tag           = addr[31 -: TAG_WIDTH];
    r.wdata              = wdata;
    r.op                 = (|wstrb) ? HPDCACHE_REQ_STORE : HPDCACHE_REQ_LOAD;
    r.be                 = (|wstrb) ? wstrb : 4'b1111;
    r.size               = 3'd2;
    r.sid                = sid;
    r.tid                = '0;
    r.need_rsp           = 1'b1;
    r.phys_indexed       = 1'b1;
    r.pma.uncacheable    = io;
    r.pma.io             = io;
    r.pma.wr_policy_hint = HPDCACHE_WR_POLICY_WB;
    return r;
  endfunction

endpackage

// File: rtl/picorv_hpdc_seq_timeout_ctr.sv
// rtl/picorv_hpdc_seq_timeout_ctr.sv - saturating access timeout counter with clear, enable and expire
module seq_timeout_ctr #(
  parameter int unsigned Limit = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (Limit > 2) ? $clog2(Limit) : 1;

  logic [W-1:0] cnt;

  assign expire_o = (cnt == W'(Limit - 1));

  // Holds at the limit so a stalled FSM keeps seeing expire instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i && !expire_o) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/picorv_hpdc_seq.sv
// rtl/picorv_hpdc_seq.sv - single-outstanding picorv32 to hpdcache request sequencer
module picorv_hpdc_seq
  import picorv_hpdc_pkg::*;
#(
  parameter logic [31:0]          PhysMemLimit  = PHYS_MEM_LIMIT,
  parameter int unsigned          TimeoutCycles = 1024,
  parameter logic [SID_WIDTH-1:0] ReqSid        = '0,
  parameter logic [31:0]          ErrRdata      = ERR_RDATA
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          mem_valid_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [31:0]   mem_wdata_i,
  input  logic [3:0]    mem_wstrb_i,
  output logic          mem_ready_o,
  output logic [31:0]   mem_rdata_o,
  output logic          core_req_valid_o,
  input  logic          core_req_ready_i,
  output hpdcache_req_t core_req_o,
  output logic          core_req_abort_o,
  output hpdcache_tag_t core_req_tag_o,
  input  logic          core_rsp_valid_i,
  input  hpdcache_rsp_t core_rsp_i,
  output logic          wbuf_flush_o,
  input  logic          wbuf_empty_i,
  output logic          err_o
);

  seq_state_e state;
  logic       stale;
  logic       rsp_match;
  logic       io_now;
  logic       expired;
  logic       ctr_clr;
  logic       ctr_en;

  assign rsp_match        = core_rsp_valid_i && (core_rsp_i.sid == ReqSid) && (core_rsp_i.tid == '0);
  assign io_now           = is_io(mem_addr_i, PhysMemLimit);
  assign core_req_abort_o = 1'b0;
  assign core_req_tag_o   = core_req_o.addr_tag;
  assign ctr_clr          = (state == IDLE);
  assign ctr_en           = (state == FLUSH) || (state == WAIT_RSP);

  seq_timeout_ctr #(
    .Limit(TimeoutCycles)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (ctr_clr),
    .en_i    (ctr_en),
    .expire_o(expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      stale            <= 1'b0;
      core_req_o       <= '0;
      core_req_valid_o <= 1'b0;
      wbuf_flush_o     <= 1'b0;
      mem_ready_o      <= 1'b0;
      mem_rdata_o      <= '0;
      err_o            <= 1'b0;
    end else begin
      mem_ready_o <= 1'b0;
      err_o       <= 1'b0;
      // A late reply to a timed-out request only retires the stale flag.
      if (stale && rsp_match) begin
        stale <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (mem_valid_i && !stale) begin
            core_req_o <= build_req(mem_addr_i, mem_wdata_i, mem_wstrb_i, io_now, ReqSid);
            if (io_now) begin
              state        <= FLUSH;
              wbuf_flush_o <= 1'b1;
            end else begin
              state            <= REQ;
              core_req_valid_o <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (wbuf_empty_i) begin
            state            <= REQ;
            wbuf_flush_o     <= 1'b0;
            core_req_valid_o <= 1'b1;
          end else if (expired) begin
            state        <= DONE;
            wbuf_flush_o <= 1'b0;
            mem_ready_o  <= 1'b1;
            mem_rdata_o  <= ErrRdata;
            err_o        <= 1'b1;
          end
        end
        REQ: begin
          if (core_req_ready_i) begin
            state            <= WAIT_RSP;
            core_req_valid_o <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (rsp_match) begin
            state       <= DONE;
            mem_ready_o <= 1'b1;
            mem_rdata_o <= core_rsp_i.error ? ErrRdata : core_rsp_i.rdata;
            err_o       <= core_rsp_i.error;
          end else if (expired) begin
            state       <= DONE;
            stale       <= 1'b1;
            mem_ready_o <= 1'b1;
            mem_rdata_o <= ErrRdata;
            err_o       <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picorv_hpdc_seq.sv
// tb/tb_picorv_hpdc_seq.sv - self-checking bench for picorv_hpdc_seq
module tb_picorv_hpdc_seq;
  import picorv_hpdc_pkg::*;

  localparam int unsigned TO    = 16;
  localparam logic [31:0] LIMIT = 32'h0002_0000;
  localparam logic [31:0] BAD   = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          mem_valid_i;
  logic [31:0]   mem_addr_i;
  logic [31:0]   mem_wdata_i;
  logic [3:0]    mem_wstrb_i;
  logic          mem_ready_o;
  logic [31:0]   mem_rdata_o;
  logic          core_req_valid_o;
  logic          core_req_ready_i;
  hpdcache_req_t core_req_o;
  logic          core_req_abort_o;
  hpdcache_tag_t core_req_tag_o;
  logic          core_rsp_valid_i;
  hpdcache_rsp_t core_rsp_i;
  logic          wbuf_flush_o;
  logic          wbuf_empty_i;
  logic          err_o;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          e_lo;
    int          r_wait;
    int          d_wait;
    bit          junk;
    bit          rsp_err;
    logic [31:0] rsp_rdata;
    bit          exp_io;
    int          exp_lat;
    int          exp_flush;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  picorv_hpdc_seq #(
    .PhysMemLimit (LIMIT),
    .TimeoutCycles(TO),
    .ReqSid       ('0),
    .ErrRdata     (BAD)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .mem_valid_i     (mem_valid_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_wstrb_i     (mem_wstrb_i),
    .mem_ready_o     (mem_ready_o),
    .mem_rdata_o     (mem_rdata_o),
    .core_req_valid_o(core_req_valid_o),
    .core_req_ready_i(core_req_ready_i),
    .core_req_o      (core_req_o),
    .core_req_abort_o(core_req_abort_o),
    .core_req_tag_o  (core_req_tag_o),
    .core_rsp_valid_i(core_rsp_valid_i),
    .core_rsp_i      (core_rsp_i),
    .wbuf_flush_o    (wbuf_flush_o),
    .wbuf_empty_i    (wbuf_empty_i),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic hpdcache_req_t exp_req(input logic [31:0] a, input logic [31:0] wd,
                                            input logic [3:0] ws, input bit io);
    hpdcache_req_t r;
    r                    = '0;
    r.addr_offset        = a[11:0];
    r.addr_tag           = a[31:12];
    r.wdata              = wd;
    r.op                 = (ws != 4'h0) ? HPDCACHE_REQ_STORE : HPDCACHE_REQ_LOAD;
    r.be                 = (ws != 4'h0) ? ws : 4'b1111;
    r.size               = 3'd2;
    r.need_rsp           = 1'b1;
    r.phys_indexed       = 1'b1;
    r.pma.uncacheable    = io;
    r.pma.io             = io;
    r.pma.wr_policy_hint = HPDCACHE_WR_POLICY_WB;
    return r;
  endfunction

  // Called in the negedge window of the cycle in which mem_valid is raised; returns in the idle cycle after mem_ready.
  task automatic do_access(input string nm, input vec_t v);
    int            c, req_cyc, xfers, xfer_c, flushes, errs, unstable, lat;
    bit            done, seen;
    hpdcache_req_t pay;
    hpdcache_tag_t tag;
    logic [31:0]   rd;
    c = 0; req_cyc = 0; xfers = 0; xfer_c = 0; flushes = 0; errs = 0; unstable = 0; lat = 0;
    done = 1'b0; seen = 1'b0; pay = '0; tag = '0; rd = '0;
    mem_valid_i = 1'b1;
    mem_addr_i  = v.addr;
    mem_wdata_i = v.wdata;
    mem_wstrb_i = v.wstrb;
    while (!done && c < 300) begin
      if (core_req_valid_o) begin
        if (!seen) begin
          pay  = core_req_o;
          tag  = core_req_tag_o;
          seen = 1'b1;
        end else if (core_req_o !== pay) begin
          unstable++;
        end
      end
      if (wbuf_flush_o) flushes++;
      if (err_o) errs++;
      if (mem_ready_o) begin
        done = 1'b1;
        lat  = c + 1;
        rd   = mem_rdata_o;
      end
      wbuf_empty_i     = (c >= v.e_lo);
      core_req_ready_i = 1'b0;
      if (core_req_valid_o) begin
        if (req_cyc >= v.r_wait) begin
          core_req_ready_i = 1'b1;
          xfers++;
          xfer_c = c;
        end
        req_cyc++;
      end
      core_rsp_valid_i = 1'b0;
      core_rsp_i       = '0;
      if (xfers > 0 && c > xfer_c) begin
        if (v.d_wait >= 0 && c == xfer_c + 1 + v.d_wait) begin
          core_rsp_valid_i = 1'b1;
          core_rsp_i.rdata = v.rsp_rdata;
          core_rsp_i.error = v.rsp_err;
        end else if (v.junk && c <= xfer_c + v.d_wait) begin
          core_rsp_valid_i = 1'b1;
          core_rsp_i.rdata = $urandom;
          core_rsp_i.error = 1'b1;
          if ((c % 2) == 1) core_rsp_i.sid = 3'd1;
          else core_rsp_i.tid = 6'd1;
        end
      end
      if (done) begin
        mem_valid_i      = 1'b0;
        core_req_ready_i = 1'b0;
        core_rsp_valid_i = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    wbuf_empty_i = 1'b1;
    check({nm, " completed"}, done, 1);
    check({nm, " latency"}, lat, v.exp_lat);
    check({nm, " transfers"}, xfers, 1);
    check({nm, " flush cycles"}, flushes, v.exp_flush);
    check({nm, " payload"}, pay, exp_req(v.addr, v.wdata, v.wstrb, v.exp_io));
    check({nm, " tag"}, tag, v.addr[31:12]);
    check({nm, " payload stable"}, unstable, 0);
    check({nm, " err pulses"}, errs, v.exp_err ? 1 : 0);
    if (v.chk_rdata) check({nm, " rdata"}, rd, v.exp_rdata);
    check({nm, " ready single pulse"}, {mem_ready_o, err_o}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   bad, sel, fl;

    mem_valid_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
    core_req_ready_i = 1'b0; core_rsp_valid_i = 1'b0; core_rsp_i = '0; wbuf_empty_i = 1'b1;

    repeat (3) @(negedge clk);
    check("reset handshake outs", {mem_ready_o, core_req_valid_o, wbuf_flush_o, err_o, core_req_abort_o}, 5'b0);
    check("reset rdata", mem_rdata_o, 32'h0);
    check("reset req payload", core_req_o, '0);
    check("reset tag", core_req_tag_o, '0);
    rst_ni = 1'b1;
    @(negedge clk);

    // addr, wdata, wstrb, e_lo, r_wait, d_wait, junk, err, rsp_rdata, io, lat, flush, chk, exp_rdata, exp_err
    vecs[0] = '{32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 4, 0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'h0000_0200, 32'hAABB_CCDD, 4'b0011, 0, 5, 0, 1'b0, 1'b0, 32'h0, 1'b0, 9, 0, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{32'h0003_0000, 32'h1122_3344, 4'b1111, 3, 0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 7, 3, 1'b0, 32'h0, 1'b0};
    vecs[3] = '{32'h0001_FFFC, 32'h0, 4'h0, 2, 0, 0, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0, 4, 0, 1'b1, 32'hCAFE_0001, 1'b0};
    vecs[4] = '{32'h0002_0000, 32'h0, 4'h0, 0, 1, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b1, 7, 1, 1'b1, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{32'h0000_0400, 32'h0, 4'h0, 0, 0, 0, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 4, 0, 1'b1, BAD, 1'b1};
    vecs[6] = '{32'h0000_0800, 32'h0, 4'h0, 0, 0, 3, 1'b1, 1'b0, 32'h1357_9BDF, 1'b0, 7, 0, 1'b1, 32'h1357_9BDF, 1'b0};
    for (int i = 0; i < 7; i++) do_access($sformatf("vec%0d", i), vecs[i]);

    v = '{32'h0000_0300, 32'h0, 4'h0, 0, 2, -1, 1'b0, 1'b0, 32'h0, 1'b0, 21, 0, 1'b1, BAD, 1'b1};
    do_access("timeout", v);

    bad = 0;
    mem_valid_i = 1'b1; mem_addr_i = 32'h0000_0500; mem_wstrb_i = 4'h0;
    for (int i = 0; i < 7; i++) begin
      if (core_req_valid_o || wbuf_flush_o || mem_ready_o || err_o) bad++;
      if (i == 6) begin
        core_rsp_valid_i = 1'b1;
        core_rsp_i       = '0;
        core_rsp_i.rdata = 32'h5555_5555;
      end
      @(negedge clk);
    end
    core_rsp_valid_i = 1'b0;
    check("stale blocks and drops late rsp", bad, 0);
    check("late rsp not forwarded", {mem_ready_o, err_o}, 2'b00);
    v = '{32'h0000_0500, 32'h0, 4'h0, 0, 0, 0, 1'b0, 1'b0, 32'h2468_ACE0, 1'b0, 4, 0, 1'b1, 32'h2468_ACE0, 1'b0};
    do_access("after stale", v);

    mem_valid_i = 1'b1; mem_addr_i = 32'h0000_0600; mem_wdata_i = 32'h12; mem_wstrb_i = 4'hF;
    core_req_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    core_req_ready_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check("async rst handshake outs", {mem_ready_o, core_req_valid_o, wbuf_flush_o, err_o}, 4'b0);
    check("async rst rdata", mem_rdata_o, 32'h0);
    check("async rst payload", core_req_o, '0);
    mem_valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    v = '{32'h0000_0700, 32'h0, 4'h0, 0, 0, 0, 1'b0, 1'b0, 32'h0F0F_0F0F, 1'b0, 4, 0, 1'b1, 32'h0F0F_0F0F, 1'b0};
    do_access("post reset", v);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) v.addr = 32'($urandom_range(0, 32'h7FFF)) << 2;
      else if (sel == 1) v.addr = LIMIT + (32'($urandom_range(0, 32'hFFFF)) << 2);
      else v.addr = ($urandom_range(0, 1) == 1) ? 32'h0001_FFFC : LIMIT;
      v.wdata     = $urandom;
      v.wstrb     = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      v.e_lo      = $urandom_range(0, 4);
      v.r_wait    = $urandom_range(0, 4);
      v.d_wait    = $urandom_range(0, 4);
      v.junk      = ($urandom_range(0, 1) == 1);
      v.rsp_err   = ($urandom_range(0, 7) == 0);
      v.rsp_rdata = $urandom;
      v.exp_io    = (v.addr >= LIMIT);
      fl          = v.exp_io ? ((v.e_lo > 1) ? v.e_lo : 1) : 0;
      v.exp_flush = fl;
      v.exp_lat   = 4 + fl + v.r_wait + v.d_wait;
      v.chk_rdata = (v.wstrb == 4'h0) || v.rsp_err;
      v.exp_rdata = v.rsp_err ? BAD : v.rsp_rdata;
      v.exp_err   = v.rsp_err;
      do_access($sformatf("rnd%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
